// File: rtl/mp_modaddsub_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mp_pkg
// Shared definitions for the modular add/subtract sequencer:
//   state_t        controller FSM states
//   OP_ADD/OP_SUB  operation encoding (value of the subtract request bit)
//   DEFAULT_WIDTH  default operand width, matching the multi-precision adder
// -----------------------------------------------------------------------------
package mp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISS1  = 3'd1,
        WAIT1 = 3'd2,
        ISS2  = 3'd3,
        WAIT2 = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEFAULT_WIDTH = 1027;

endpackage

// File: rtl/mp_modaddsub_ctrl_if.sv
// -----------------------------------------------------------------------------
// mp_modaddsub_ctrl_if
// Start/done handshake bus between the sequencer and one multi-precision adder.
//   add_start     one-cycle start pulse to the adder
//   add_subtract  0 = a+b, 1 = a+~b+1
//   add_in_a/b    adder operands, held stable while the adder runs
//   add_result    WIDTH+1 bit sum, bit WIDTH is the carry-out
//   add_done      one-cycle completion pulse from the adder
// Modports: master = sequencer side, slave = adder side.
// -----------------------------------------------------------------------------
interface mp_modaddsub_ctrl_if
    import mp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             add_start;
    logic             add_subtract;
    logic [WIDTH-1:0] add_in_a;
    logic [WIDTH-1:0] add_in_b;
    logic [WIDTH:0]   add_result;
    logic             add_done;

    modport master (
        output add_start,
        output add_subtract,
        output add_in_a,
        output add_in_b,
        input  add_result,
        input  add_done
    );

    modport slave (
        input  add_start,
        input  add_subtract,
        input  add_in_a,
        input  add_in_b,
        output add_result,
        output add_done
    );

endinterface

// File: rtl/mp_modaddsub_ctrl.sv
// -----------------------------------------------------------------------------
// mp_modaddsub_ctrl
// Sequencer computing (a+b) mod m or (a-b) mod m with an external adder.
// Two adder operations are always chained:
//   add: r1 = a+b, then r1-m; keep r1-m when it does not borrow
//   sub: r1 = a-b, then r1+m; keep r1 when a-b did not borrow
// Latency is data independent: done comes 2L+3 cycles after start, L being
// the adder latency from add_start to add_done.
// Ports:
//   clk, resetn        clock, synchronous active-high reset
//   start, subtract    request pulse (IDLE only) and operation select
//   in_a, in_b, in_m   operands (a,b < m, 0 < m < 2^(WIDTH-1))
//   result, done       reduced result in [0,m) and one-cycle completion pulse
//   add_bus            master side of the adder handshake
// -----------------------------------------------------------------------------
module mp_modaddsub_ctrl
    import mp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 subtract,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [WIDTH-1:0]     in_m,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    mp_modaddsub_ctrl_if.master  add_bus
);

    state_t           state;
    state_t           state_nxt;

    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] m;
    logic [WIDTH:0]   r1;

    // Pick the reduced value from the first (r1) and second adder results.
    // Add: a carry from r1-m means r1 >= m, so the subtraction is kept.
    // Sub: a carry from a-b means no borrow, so r1 is already reduced; the
    // carry of r1+m is meaningless and ignored.
    function automatic logic [WIDTH-1:0] select_reduced(
        input logic           sel_op,
        input logic [WIDTH:0] first,
        input logic [WIDTH:0] second
    );
        logic [WIDTH-1:0] sel;
        if (sel_op == OP_ADD) begin
            sel = second[WIDTH] ? second[WIDTH-1:0] : first[WIDTH-1:0];
        end else begin
            sel = first[WIDTH] ? first[WIDTH-1:0] : second[WIDTH-1:0];
        end
        return sel;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; add_done outside the wait states is ignored
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISS1;
            ISS1:    state_nxt = WAIT1;
            WAIT1:   if (add_bus.add_done) state_nxt = ISS2;
            ISS2:    state_nxt = WAIT2;
            WAIT2:   if (add_bus.add_done) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, first-result capture and result register
    always_ff @(posedge clk) begin
        if (resetn) begin
            op     <= OP_ADD;
            a      <= '0;
            b      <= '0;
            m      <= '0;
            r1     <= '0;
            result <= '0;
        end else begin
            if (state == IDLE && start) begin
                op <= subtract;
                a  <= in_a;
                b  <= in_b;
                m  <= in_m;
            end
            if (state == WAIT1 && add_bus.add_done) begin
                r1 <= add_bus.add_result;
            end
            if (state == WAIT2 && add_bus.add_done) begin
                result <= select_reduced(op, r1, add_bus.add_result);
            end
        end
    end

    // Outputs decoded from state; operands stay stable across each
    // issue/wait pair so the adder may sample them at any point.
    always_comb begin
        add_bus.add_start    = 1'b0;
        add_bus.add_subtract = 1'b0;
        add_bus.add_in_a     = '0;
        add_bus.add_in_b     = '0;
        done                 = 1'b0;
        case (state)
            ISS1, WAIT1: begin
                add_bus.add_start    = (state == ISS1);
                add_bus.add_subtract = op;
                add_bus.add_in_a     = a;
                add_bus.add_in_b     = b;
            end
            ISS2, WAIT2: begin
                // add: r1-m, sub: r1+m
                add_bus.add_start    = (state == ISS2);
                add_bus.add_subtract = ~op;
                add_bus.add_in_a     = r1[WIDTH-1:0];
                add_bus.add_in_b     = m;
            end
            FIN: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

endmodule
